// File: rtl/vend_dispense_ctrl_if.sv
// Dispense-controller bus: the vend event, sensor and hopper acks going in,
// and the motor, hopper requests and status flags coming out.
//
// Handshake rule for both hoppers: a request stays high until the controller
// samples the matching ack high on a rising edge. That edge completes exactly
// one coin transfer and drops the request. An ack seen while the request is
// low carries no meaning.
interface vend_dispense_ctrl_if;
  logic       i_vend_valid;
  logic [2:0] i_change;
  logic       i_soda_done;
  logic       i_dime_ack;
  logic       i_nickel_ack;
  logic       o_coin_inhibit;
  logic       o_soda_motor;
  logic       o_dime_req;
  logic       o_nickel_req;
  logic       o_done;
  logic       o_fault;

  // Controller side.
  modport slave (
    input  i_vend_valid, i_change, i_soda_done, i_dime_ack, i_nickel_ack,
    output o_coin_inhibit, o_soda_motor, o_dime_req, o_nickel_req, o_done, o_fault
  );

  // Vending FSM / hopper / sensor side.
  modport master (
    output i_vend_valid, i_change, i_soda_done, i_dime_ack, i_nickel_ack,
    input  o_coin_inhibit, o_soda_motor, o_dime_req, o_nickel_req, o_done, o_fault
  );
endinterface

// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer: soda motor pulse, wait for motor-done, then change paid
// as dimes followed by at most one nickel. Coin inhibit covers the whole run.
// All outputs are registered; the state is exported on o_dbg_state.
//
// Optional build macro: DISPENSE_TIMEOUT_EN adds a watchdog over the
// SODA_WAIT, DIME and NICKEL waits and a sticky FAULT state left only by reset.
module vend_dispense_ctrl #(
  parameter int unsigned SODA_PULSE = 8,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  vend_dispense_ctrl_if.slave   bus,
  output logic [2:0]            o_dbg_state
);

  localparam int unsigned CNT_W = $clog2(SODA_PULSE + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SODA      = 3'd1,
    SODA_WAIT = 3'd2,
    DIME      = 3'd3,
    DIME_GAP  = 3'd4,
    NICKEL    = 3'd5,
`ifdef DISPENSE_TIMEOUT_EN
    DONE      = 3'd6,
    FAULT     = 3'd7
`else
    DONE      = 3'd6
`endif
  } state_t;

  state_t           state_q;
  state_t           after_state;
  logic [CNT_W-1:0] pulse_q;
  logic [1:0]       dime_cnt_q;
  logic             nick_q;
  logic             motor_q;
  logic             dime_req_q;
  logic             nickel_req_q;
  logic             done_q;
  logic             inhibit_q;

  // Change codes above 20c are invalid and pay nothing.
  logic [1:0] change_dimes;
  logic       change_nick;
  assign change_dimes = bus.i_change[2] ? ((bus.i_change[1:0] == 2'b00) ? 2'd2 : 2'd0)
                                        : {1'b0, bus.i_change[1]};
  assign change_nick  = ~bus.i_change[2] & bus.i_change[0];

  // Where to go once the motor is done or a dime gap ends: dimes first.
  always_comb begin
    if (dime_cnt_q != 2'd0) begin
      after_state = DIME;
    end else if (nick_q) begin
      after_state = NICKEL;
    end else begin
      after_state = DONE;
    end
  end

`ifdef DISPENSE_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wdog_q;
  logic [WD_W-1:0] wdog_d;
  logic            watched;
  logic            leaving;
  logic            wdog_hit;
  logic            fault_q;

  // Watchdog runs only while waiting on the outside world and restarts on
  // every state change, so each wait gets its own TIMEOUT budget.
  always_comb begin
    watched  = (state_q == SODA_WAIT) || (state_q == DIME) || (state_q == NICKEL);
    leaving  = ((state_q == SODA_WAIT) && bus.i_soda_done) ||
               ((state_q == DIME)      && bus.i_dime_ack)  ||
               ((state_q == NICKEL)    && bus.i_nickel_ack);
    wdog_hit = watched && (wdog_q == WD_W'(TIMEOUT - 1));
    wdog_d   = (watched && !leaving) ? wdog_q + 1'b1 : '0;
  end

  // Watchdog count register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  // Main sequencer with registered Moore outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      pulse_q      <= '0;
      dime_cnt_q   <= 2'd0;
      nick_q       <= 1'b0;
      motor_q      <= 1'b0;
      dime_req_q   <= 1'b0;
      nickel_req_q <= 1'b0;
      done_q       <= 1'b0;
      inhibit_q    <= 1'b0;
`ifdef DISPENSE_TIMEOUT_EN
      fault_q      <= 1'b0;
`endif
    end
`ifdef DISPENSE_TIMEOUT_EN
    else if (wdog_hit) begin
      state_q      <= FAULT;
      motor_q      <= 1'b0;
      dime_req_q   <= 1'b0;
      nickel_req_q <= 1'b0;
      done_q       <= 1'b0;
      inhibit_q    <= 1'b1;
      fault_q      <= 1'b1;
    end
`endif
    else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.i_vend_valid) begin
            state_q    <= SODA;
            dime_cnt_q <= change_dimes;
            nick_q     <= change_nick;
            pulse_q    <= '0;
            motor_q    <= 1'b1;
            inhibit_q  <= 1'b1;
          end
        end
        SODA: begin
          if (pulse_q == CNT_W'(SODA_PULSE - 1)) begin
            state_q <= SODA_WAIT;
            pulse_q <= '0;
            motor_q <= 1'b0;
          end else begin
            pulse_q <= pulse_q + 1'b1;
          end
        end
        SODA_WAIT: begin
          if (bus.i_soda_done) begin
            state_q      <= after_state;
            dime_req_q   <= (after_state == DIME);
            nickel_req_q <= (after_state == NICKEL);
            done_q       <= (after_state == DONE);
          end
        end
        DIME: begin
          if (bus.i_dime_ack) begin
            state_q    <= DIME_GAP;
            dime_cnt_q <= dime_cnt_q - 2'd1;
            dime_req_q <= 1'b0;
          end
        end
        DIME_GAP: begin
          state_q      <= after_state;
          dime_req_q   <= (after_state == DIME);
          nickel_req_q <= (after_state == NICKEL);
          done_q       <= (after_state == DONE);
        end
        NICKEL: begin
          if (bus.i_nickel_ack) begin
            state_q      <= DONE;
            nick_q       <= 1'b0;
            nickel_req_q <= 1'b0;
            done_q       <= 1'b1;
          end
        end
        DONE: begin
          state_q   <= IDLE;
          inhibit_q <= 1'b0;
        end
        default: begin
          // FAULT (when built in) holds until reset.
        end
      endcase
    end
  end

  assign bus.o_coin_inhibit = inhibit_q;
  assign bus.o_soda_motor   = motor_q;
  assign bus.o_dime_req     = dime_req_q;
  assign bus.o_nickel_req   = nickel_req_q;
  assign bus.o_done         = done_q;
`ifdef DISPENSE_TIMEOUT_EN
  assign bus.o_fault        = fault_q;
`else
  assign bus.o_fault        = 1'b0;
`endif
  assign o_dbg_state        = state_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Table-driven bench for vend_dispense_ctrl: each record gives a change code,
// sensor/ack latencies and the hand-computed counts and done cycle.
module tb_vend_dispense_ctrl;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;
  int         checks   = 0;
  int         failures = 0;

  vend_dispense_ctrl_if bus ();

  vend_dispense_ctrl #(.SODA_PULSE(8), .TIMEOUT(16)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0] change;
    int soda_lat;   // cycles of motor-low before soda_done rises
    int dime_lat;   // req-high cycles before dime ack
    int nick_lat;   // req-high cycles before nickel ack
    int stray_n;    // cycle of stray vend/acks/soda_done (0 = none)
    int motor;      // expected motor-high cycles
    int dimes;
    int nicks;
    int dreq;       // expected dime-req-high cycles
    int nreq;       // expected nickel-req-high cycles
    int done_n;     // cycle (after the accept edge) where o_done is seen
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int outs_packed();
    return {26'd0, bus.o_coin_inhibit, bus.o_soda_motor, bus.o_dime_req,
            bus.o_nickel_req, bus.o_done, bus.o_fault};
  endfunction

  task automatic clear_inputs();
    bus.i_vend_valid = 1'b0;
    bus.i_change     = 3'b000;
    bus.i_soda_done  = 1'b0;
    bus.i_dime_ack   = 1'b0;
    bus.i_nickel_ack = 1'b0;
  endtask

  // Driver + monitor for one full vend; inputs change on the falling edge.
  task automatic run_vend(input string tag, input vec_t v);
    int n = 0, motor_c = 0, dimes = 0, nicks = 0, dreq_c = 0, nreq_c = 0;
    int done_c = 0, done_n = 0, inh_c = 0, fall_c = 0, dwait = 0, nwait = 0;
    bit motor_seen = 0, order_bad = 0, finished = 0;
    @(negedge clk);
    bus.i_vend_valid = 1'b1;
    bus.i_change     = v.change;
    while (!finished && n < 300) begin
      @(negedge clk);
      n++;
      bus.i_vend_valid = 1'b0;
      bus.i_dime_ack   = 1'b0;
      bus.i_nickel_ack = 1'b0;
      if (bus.o_soda_motor) begin
        motor_c++;
        motor_seen = 1;
      end else if (motor_seen) begin
        fall_c++;
      end
      if (done_n == 0 && bus.o_coin_inhibit) inh_c++;
      if (bus.o_done) begin
        done_c++;
        if (done_n == 0) done_n = n;
      end
      if (bus.o_dime_req) begin
        dreq_c++;
        dwait++;
        if (dwait > v.dime_lat) begin
          bus.i_dime_ack = 1'b1;
          dimes++;
          if (nicks > 0) order_bad = 1;
        end
      end else begin
        dwait = 0;
      end
      if (bus.o_nickel_req) begin
        nreq_c++;
        nwait++;
        if (nwait > v.nick_lat) begin
          bus.i_nickel_ack = 1'b1;
          nicks++;
        end
      end else begin
        nwait = 0;
      end
      bus.i_soda_done = (fall_c > v.soda_lat);
      if (n == v.stray_n) begin
        bus.i_vend_valid = 1'b1;
        bus.i_change     = 3'b100;
        bus.i_dime_ack   = 1'b1;
        bus.i_nickel_ack = 1'b1;
        bus.i_soda_done  = 1'b1;
      end
      if (done_n != 0 && n == done_n + 1) begin
        check({tag, "_inhibit_after"}, int'(bus.o_coin_inhibit), 0);
        check({tag, "_idle_after"}, int'(dbg_state), 0);
        finished = 1;
      end
    end
    clear_inputs();
    if (!finished) begin
      check({tag, "_timeout"}, n, -1);
    end else begin
      check({tag, "_motor_cycles"}, motor_c, v.motor);
      check({tag, "_dimes"}, dimes, v.dimes);
      check({tag, "_nickels"}, nicks, v.nicks);
      check({tag, "_dime_req_cycles"}, dreq_c, v.dreq);
      check({tag, "_nickel_req_cycles"}, nreq_c, v.nreq);
      check({tag, "_done_pulses"}, done_c, 1);
      check({tag, "_done_cycle"}, done_n, v.done_n);
      check({tag, "_inhibit_cycles"}, inh_c, v.done_n);
      check({tag, "_order"}, int'(order_bad), 0);
    end
  endtask

`ifdef DISPENSE_TIMEOUT_EN
  // Watchdog: motor-done never arrives, FAULT after 16 SODA_WAIT cycles.
  task automatic timeout_seq();
    int fc = 0, fault_fc = 0;
    bit mseen = 0, seen = 0;
    @(negedge clk);
    bus.i_vend_valid = 1'b1;
    bus.i_change     = 3'b000;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      bus.i_vend_valid = 1'b0;
      if (bus.o_soda_motor) mseen = 1;
      else if (mseen) fc++;
      if (bus.o_fault) begin
        seen = 1;
        fault_fc = fc;
      end
    end
    check("wd_fault_seen", int'(seen), 1);
    check("wd_fault_cycle", fault_fc, 17);
    repeat (20) @(negedge clk);
    check("wd_fault_outs", outs_packed(), 6'b100001);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("wd_after_reset", outs_packed(), 0);
  endtask
`endif

  initial begin
    //              chg   soda dime nick stray motor d  n  dreq nreq done
    vecs[0] = '{3'b000, 2, 0, 0, 0, 8, 0, 0, 0, 0, 12};
    vecs[1] = '{3'b100, 0, 1, 1, 0, 8, 2, 0, 4, 0, 16};
    vecs[2] = '{3'b011, 0, 5, 0, 0, 8, 1, 1, 6, 1, 18};
    vecs[3] = '{3'b001, 1, 0, 2, 0, 8, 0, 1, 0, 3, 14};
    vecs[4] = '{3'b010, 0, 0, 0, 0, 8, 1, 0, 1, 0, 12};
    vecs[5] = '{3'b111, 0, 0, 0, 0, 8, 0, 0, 0, 0, 10};
    vecs[6] = '{3'b101, 0, 0, 0, 0, 8, 0, 0, 0, 0, 10};
    vecs[7] = '{3'b110, 0, 0, 0, 0, 8, 0, 0, 0, 0, 10};
    vecs[8] = '{3'b011, 0, 0, 0, 3, 8, 1, 1, 1, 1, 13};
    vecs[9] = '{3'b100, 3, 2, 0, 5, 8, 2, 0, 6, 0, 8 + 4 + 2 * 4 + 1};

    clear_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs", outs_packed(), 0);
    check("reset_state", int'(dbg_state), 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_vend($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset while paying the first of two dimes.
    begin
      bit got_req = 0;
      @(negedge clk);
      bus.i_vend_valid = 1'b1;
      bus.i_change     = 3'b100;
      @(negedge clk);
      bus.i_vend_valid = 1'b0;
      bus.i_soda_done  = 1'b1;
      for (int k = 0; k < 40 && !got_req; k++) begin
        @(negedge clk);
        if (bus.o_dime_req) got_req = 1;
      end
      check("mid_rst_reached_dime", int'(got_req), 1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_outs", outs_packed(), 0);
      check("mid_rst_state", int'(dbg_state), 0);
      rst = 1'b0;
      clear_inputs();
      run_vend("post_rst", '{3'b001, 0, 0, 0, 0, 8, 0, 1, 0, 1, 8 + 1 + 1 + 1});
    end

`ifdef DISPENSE_TIMEOUT_EN
    timeout_seq();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vend_dispense_ctrl.md
Name: vend_dispense_ctrl

Overview:
- Sequences the physical dispense hardware behind the vending FSM.
- Accepts one vend event (soda + 3-bit change code) and drives the soda motor for a fixed pulse, then waits for the motor-done sensor.
- Pays change as dimes first, then a nickel, using a req/ack handshake to the dime and nickel hoppers.
- Holds coin inhibit for the whole sequence so the coin path cannot advance mid-dispense.

Parameters:
- SODA_PULSE, 8: motor-on cycles per vend; must be at least 1.
- TIMEOUT, 1024: watchdog limit in cycles. Used only when DISPENSE_TIMEOUT_EN is defined.

Ports:
- i_clk  input  1  system clock; all logic is on the rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_vend_valid  input  1  single-cycle vend event from the vending FSM.
- i_change  input  3  change code: 000=0c, 001=5c, 010=10c, 011=15c, 100=20c.
- i_soda_done  input  1  motor-done sensor, level.
- i_dime_ack  input  1  dime hopper accepted the request.
- i_nickel_ack  input  1  nickel hopper accepted the request.
- o_coin_inhibit  output  1  high whenever the state is not IDLE.
- o_soda_motor  output  1  motor drive.
- o_dime_req  output  1  dime dispense request.
- o_nickel_req  output  1  nickel dispense request.
- o_done  output  1  one-cycle pulse when a sequence completes.
- o_fault  output  1  sticky fault flag; constant 0 when the macro is not defined.

Behaviour:
- Clock and reset: one clock (i_clk). Reset i_rst is synchronous, active-high.
- Reset values: all outputs 0, state IDLE, all counters 0.
- Reset asserted mid-sequence aborts immediately: outputs are 0 at the next edge and no partial state is kept.
- All outputs are registered (Moore).
- States: IDLE, SODA, SODA_WAIT, DIME, DIME_GAP, NICKEL, DONE, plus FAULT when the macro is defined.
- IDLE:
  - On i_vend_valid, latch dime_cnt = i_change[2:1] (2 bits) and nick = i_change[0], then go to SODA.
  - Codes 101..111 are treated as 000.
  - i_vend_valid is ignored in every state except IDLE.
- SODA:
  - o_soda_motor is high for exactly SODA_PULSE cycles; the motor goes high the cycle after the event is accepted.
  - Then go to SODA_WAIT.
- SODA_WAIT:
  - When i_soda_done=1, go to DIME if dime_cnt!=0, else NICKEL if nick=1, else DONE.
  - i_soda_done sampled high during SODA is not counted.
- DIME:
  - o_dime_req is held high until sampled with i_dime_ack=1.
  - In that cycle dime_cnt decrements and the state moves to DIME_GAP (req low for 1 cycle).
  - From DIME_GAP go to DIME if dime_cnt!=0, else NICKEL if nick=1, else DONE.
- NICKEL: o_nickel_req is held high until i_nickel_ack=1, then clear nick and go to DONE.
- Stray acks: an ack arriving while the matching req is low is ignored and does not decrement any count.
- DONE: o_done=1 for one cycle, then IDLE. o_coin_inhibit drops in the IDLE cycle.
- Latency: with zero-latency sensor/acks, a 20c vend runs event → 1 latch cycle → SODA_PULSE → 1 wait → DIME → GAP → DIME → GAP → DONE.

Optional Feature:
- Macro: DISPENSE_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on every state change and counts cycles spent in SODA_WAIT, DIME or NICKEL.
  - When it reaches TIMEOUT, go to FAULT: all requests and the motor go low, o_fault=1, o_coin_inhibit=1.
  - FAULT is left only by i_rst.
- Not defined:
  - No watchdog logic.
  - Handshake waits are unbounded.
  - o_fault is tied to 0.

Test Plan:
- Reset then i_vend_valid with i_change=000, i_soda_done high 2 cycles after motor off → o_soda_motor high exactly 8 cycles, no hopper requests, one o_done pulse, o_coin_inhibit low afterward.
- i_change=100 (20c), acks 1 cycle after req → exactly 2 dime handshakes separated by a req-low gap, 0 nickel, o_done once.
- i_change=011 (15c), i_dime_ack delayed 5 cycles → o_dime_req held all 5 cycles, 1 dime then 1 nickel, order dime before nickel.
- Second i_vend_valid during SODA, and i_nickel_ack pulsed while o_nickel_req low → both ignored; dispense counts unchanged.
- i_rst asserted during DIME with dime_cnt=2 → next cycle all outputs 0 and IDLE; a new vend with 001 dispenses only 1 nickel.
- With DISPENSE_TIMEOUT_EN and TIMEOUT=16, i_soda_done never asserted → o_fault=1 after 16 cycles in SODA_WAIT, motor/req low, stays until i_rst.
